pdm_mic_capture: RTL

//  Front end of the PCM microphone audio path. Generates the PDM microphone clock and samples the 1-bit PDM stream.

---
 rtl/pdm_mic_capture.sv | 183 ++++++++++++++++++
 1 files changed

// File: rtl/pdm_mic_capture.sv
// rtl/pdm_mic_capture.sv - PDM microphone clock generator, ones-count decimator and FIFO write strobe
module pdm_mic_capture #(
    parameter int CLK_DIV = 25,
    parameter int DECIM   = 256,
    parameter int dbits   = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             enable,
    input  logic             mic_data,
    output logic             mic_clk,
    output logic             mic_lr,
    output logic [dbits-1:0] din,
    output logic             wr,
    input  logic             full,
    output logic             overrun
);

    localparam int LOG_D = $clog2(DECIM);
    localparam int DIV_W = $clog2(CLK_DIV);
    localparam logic [DIV_W-1:0] DIV_LAST    = DIV_W'(CLK_DIV - 1);
    localparam logic [LOG_D-1:0] BIT_LAST    = LOG_D'(DECIM - 1);
    localparam logic [1:0]       STROBE_LAST = 2'd1;
    localparam logic [1:0]       HOLD_LAST   = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_STROBE = 2'd1,
        ST_HOLD   = 2'd2
    } state_t;

    logic [DIV_W-1:0] r_div_cnt;
    logic             r_mic_clk;
    logic             r_sync1;
    logic             r_sync2;
    logic [LOG_D-1:0] r_bit_cnt;
    logic [LOG_D:0]   r_ones;
    state_t           r_state;
    logic [1:0]       r_phase;
    logic             r_wr;
    logic [dbits-1:0] r_din;
    logic             r_overrun;

    logic             w_div_wrap;
    logic             w_bit_take;
    logic             w_close;
    logic [LOG_D:0]   w_ones_total;
    logic [LOG_D-1:0] w_clamped;
    logic [dbits-1:0] w_sample;
    state_t           w_state_nxt;
    logic [1:0]       w_phase_nxt;
    logic             w_load;
    logic             w_drop;

    assign w_div_wrap = enable && (r_div_cnt == DIV_LAST);
    // A PDM bit is taken on the cycle mic_clk is about to fall.
    assign w_bit_take = w_div_wrap && r_mic_clk;
    assign w_close    = w_bit_take && (r_bit_cnt == BIT_LAST);

    assign w_ones_total = r_ones + {{LOG_D{1'b0}}, r_sync2};
    // Only a full window of ones reaches DECIM; it saturates to all ones.
    assign w_clamped    = w_ones_total[LOG_D] ? {LOG_D{1'b1}} : w_ones_total[LOG_D-1:0];
    assign w_sample     = w_clamped[LOG_D-1 -: dbits];

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_div_cnt <= '0;
            r_mic_clk <= 1'b0;
        end else if (!enable) begin
            r_div_cnt <= '0;
            r_mic_clk <= 1'b0;
        end else if (w_div_wrap) begin
            r_div_cnt <= '0;
            r_mic_clk <= ~r_mic_clk;
        end else begin
            r_div_cnt <= r_div_cnt + DIV_W'(1);
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
        end else begin
            r_sync1 <= mic_data;
            r_sync2 <= r_sync1;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_bit_cnt <= '0;
            r_ones    <= '0;
        end else if (!enable) begin
            r_bit_cnt <= '0;
            r_ones    <= '0;
        end else if (w_bit_take) begin
            if (r_bit_cnt == BIT_LAST) begin
                r_bit_cnt <= '0;
                r_ones    <= '0;
            end else begin
                r_bit_cnt <= r_bit_cnt + LOG_D'(1);
                r_ones    <= w_ones_total;
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_phase_nxt = r_phase;
        w_load      = 1'b0;
        w_drop      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_close) begin
                    if (full) begin
                        w_drop = 1'b1;
                    end else begin
                        w_load      = 1'b1;
                        w_state_nxt = ST_STROBE;
                        w_phase_nxt = 2'd0;
                    end
                end
            end
            ST_STROBE: begin
                w_drop = w_close;
                if (r_phase == STROBE_LAST) begin
                    w_state_nxt = ST_HOLD;
                    w_phase_nxt = 2'd0;
                end else begin
                    w_phase_nxt = r_phase + 2'd1;
                end
            end
            ST_HOLD: begin
                w_drop = w_close;
                if (r_phase == HOLD_LAST) begin
                    w_state_nxt = ST_IDLE;
                    w_phase_nxt = 2'd0;
                end else begin
                    w_phase_nxt = r_phase + 2'd1;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_phase_nxt = 2'd0;
            end
        endcase
    end

    // The handshake is deliberately independent of enable so an in-flight write completes.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
            r_phase <= 2'd0;
            r_wr    <= 1'b0;
            r_din   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_phase <= w_phase_nxt;
            r_wr    <= (w_state_nxt == ST_STROBE);
            if (w_load) begin
                r_din <= w_sample;
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_overrun <= 1'b0;
        end else if (!enable) begin
            r_overrun <= 1'b0;
        end else if (w_drop) begin
            r_overrun <= 1'b1;
        end
    end

    assign mic_clk = r_mic_clk;
    assign mic_lr  = 1'b0;
    assign din     = r_din;
    assign wr      = r_wr;
    assign overrun = r_overrun;

endmodule
